encoder_83_seq: RTL

ENCODER_83_SEQ -- requirements
Module: encoder_83_seq

---
 rtl/encoder_pkg.sv | 18 +
 rtl/prio_enc_8.sv | 33 +++
 rtl/encoder_83_seq.sv | 110 +++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared definitions for the sequential 8-to-3 priority encoder.
//   IN_W / CODE_W : request-vector and code widths
//   EN_ACTIVE     : the only enable-group code that activates the block
//   state_e       : FSM states of encoder_83_seq
package encoder_pkg;

  localparam int IN_W   = 8;
  localparam int CODE_W = 3;

  localparam logic [2:0] EN_ACTIVE = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/prio_enc_8.sv
// Combinational 8-bit priority selector.
//   vec_i        : request vector
//   high_first_i : 1 = highest set bit wins, 0 = lowest set bit wins
//   idx_o        : index of the winning bit (0 when vec_i is all-zero)
//   any_o        : at least one bit of vec_i is set
module prio_enc_8
  import encoder_pkg::*;
(
  input  logic [IN_W-1:0]   vec_i,
  input  logic              high_first_i,
  output logic [CODE_W-1:0] idx_o,
  output logic              any_o
);

  // NOTE: every output gets a default before the loops so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    // The last matching assignment wins, so the scan direction is the
    // reverse of the priority direction.
    if (high_first_i) begin
      for (int i = 0; i < IN_W; i++) begin
        if (vec_i[i]) idx_o = CODE_W'(i);
      end
    end else begin
      for (int i = IN_W - 1; i >= 0; i--) begin
        if (vec_i[i]) idx_o = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/encoder_83_seq.sv
// Sequential 8-to-3 encoder: captures a multi-hot request vector and emits the
// index of every set bit once, in priority order, with a valid/ack handshake.
//   clk, rst : clock and synchronous active-high reset
//   en       : enable group, active only at EN_ACTIVE; otherwise aborts work
//   load     : capture data_in when idle and enabled
//   data_in  : request vector, bit i requests code i
//   ack      : consumer accepts data_out while valid is high
//   data_out : registered code being served
//   valid    : registered, data_out awaits ack
//   busy     : FSM is not idle
//   empty    : pending vector is all-zero
module encoder_83_seq
  import encoder_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        en,
  input  logic              load,
  input  logic [IN_W-1:0]   data_in,
  input  logic              ack,
  output logic [CODE_W-1:0] data_out,
  output logic              valid,
  output logic              busy,
  output logic              empty
);

  state_e              state_q,    state_d;
  logic [IN_W-1:0]     pending_q,  pending_d;
  logic [CODE_W-1:0]   data_out_q, data_out_d;
  logic                valid_q,    valid_d;

  logic                en_ok;
  logic [CODE_W-1:0]   sel_idx;
  logic                sel_any;

  assign en_ok = (en == EN_ACTIVE);

  prio_enc_8 u_prio (
    .vec_i        (pending_q),
    .high_first_i (HIGH_FIRST),
    .idx_o        (sel_idx),
    .any_o        (sel_any)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    data_out_d = data_out_q;
    valid_d    = valid_q;

    if (state_q != ST_IDLE && !en_ok) begin
      // Losing the enable mid-operation discards all outstanding work.
      state_d    = ST_IDLE;
      pending_d  = '0;
      data_out_d = '0;
      valid_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (load && en_ok) begin
            pending_d = data_in;
            state_d   = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!sel_any) begin
            state_d = ST_IDLE;
          end else begin
            data_out_d = sel_idx;
            valid_d    = 1'b1;
            state_d    = ST_OUT;
          end
        end
        ST_OUT: begin
          // Retiring the served bit is what guarantees no code repeats.
          if (ack) begin
            pending_d[data_out_q] = 1'b0;
            valid_d               = 1'b0;
            state_d               = ST_SCAN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

  assign data_out = data_out_q;
  assign valid    = valid_q;
  assign busy     = (state_q != ST_IDLE);
  assign empty    = (pending_q == '0);

endmodule
